hazard_forward_ctrl: RTL and testbench
======================================

Name: hazard_forward_ctrl

Overview:
Pipeline hazard controller for the 5-stage core. It drives the select inputs of the operand-forwarding muxes in EX and generates load-use stalls and branch flushes. It keeps its own shadow copy of per-stage destination and source register info for EX, MEM and WB. All pipeline-register enable and bubble controls come from this block.

Parameters:
REG_ADDR_W, 5, register-file address width
CNT_W, 16, width of saturating stall/flush performance counters

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
id_valid  input  1  ID stage holds a real instruction
id_rs  input  REG_ADDR_W  ID source register A
id_rt  input  REG_ADDR_W  ID source register B
id_uses_rs  input  1  ID instruction reads rs
id_uses_rt  input  1  ID instruction reads rt
id_rd  input  REG_ADDR_W  ID destination register
id_reg_write  input  1  ID instruction writes the register file
id_mem_read  input  1  ID instruction is a load
branch_taken  input  1  branch resolved taken in EX this cycle
fwd_a_sel  output  2  EX operand A mux select: 00 regfile, 01 MEM result, 10 WB result
fwd_b_sel  output  2  EX operand B mux select, same encoding
stall  output  1  load-use stall this cycle
pc_write_en  output  1  PC register enable
ifid_write_en  output  1  IF/ID register enable
ifid_flush  output  1  clear IF/ID to NOP
idex_bubble  output  1  load NOP into ID/EX
stall_count  output  CNT_W  saturating count of stall cycles
flush_count  output  CNT_W  saturating count of flush cycles

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous and active-low.
- Shadow state:
  - EX slot: ex_valid, ex_rs, ex_rt, ex_uses_rs, ex_uses_rt, ex_rd, ex_wr, ex_memrd.
  - MEM slot: mem_valid, mem_rd, mem_wr.
  - WB slot: wb_valid, wb_rd, wb_wr.
- Reset: all shadow valids 0, all fields 0, both counters 0. Outputs after reset: fwd_*_sel=00, stall=0, pc_write_en=1, ifid_write_en=1, ifid_flush=0, idex_bubble=0.
- Stall (combinational):
  - stall = id_valid & ex_valid & ex_memrd & ex_wr & (ex_rd!=0) & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)) & ~branch_taken.
  - branch_taken masks stall, because the ID instruction is being killed.
- Control outputs (combinational):
  - pc_write_en = ifid_write_en = ~stall.
  - ifid_flush = branch_taken.
  - idex_bubble = stall | branch_taken.
- Forwarding (combinational, EX slot vs older stages):
  - fwd_a_sel = 01 if ex_valid & ex_uses_rs & mem_valid & mem_wr & mem_rd!=0 & mem_rd==ex_rs.
  - Else fwd_a_sel = 10 if the same condition holds with WB fields.
  - Else fwd_a_sel = 00.
  - fwd_b_sel: identical, using ex_rt / ex_uses_rt.
  - MEM has priority over WB when both match. Register 0 is never forwarded.
- Shadow advance, every rising clk:
  - wb <= mem and mem <= ex, always; MEM and WB never stall.
  - If idex_bubble: ex_valid <= 0 and all EX fields <= 0.
  - Else: EX fields <= ID inputs, ex_valid <= id_valid.
- Stalls: a load-use stall lasts exactly 1 cycle. After the bubble the load sits in MEM, stall drops, and the consumer gets fwd=10 in the next EX cycle.
- Flush: branch_taken and stall in the same cycle resolves as flush wins (stall=0, ifid_flush=1, idex_bubble=1).
- Counters:
  - stall_count increments on every cycle with stall=1.
  - flush_count increments on every cycle with branch_taken=1.
  - Both saturate at all ones; no wrap.
- Invalid inputs: when id_valid=0, the id_* fields are don't-care and never cause stalls.

Test Plan:
- Reset mid-operation: assert rst_n=0 while stall=1 and counters are nonzero -> all outputs return to reset values immediately, with no clk edge needed.
- ALU back-to-back: issue add r3 (rd=3, wr=1), then sub rs=3 -> one cycle later fwd_a_sel=01, stall=0. With one unrelated instruction between them -> fwd_a_sel=10.
- Double match: r5 written in both MEM and WB, EX reads rt=5 -> fwd_b_sel=01 (MEM priority).
- Register 0: EX reads rs=0 while MEM writes rd=0 -> fwd_a_sel=00.
- Load-use: load rd=7 in EX, ID reads rs=7 ->
  - stall=1, pc_write_en=0, idex_bubble=1 for exactly 1 cycle, and stall_count goes 0->1.
  - Next cycle: stall=0. The cycle after: fwd_a_sel=10.
- Branch over stall: branch_taken=1 while a load-use condition exists -> stall=0, ifid_flush=1, idex_bubble=1, flush_count+1, stall_count unchanged.
- Saturation: hold the stall condition for more than 2^CNT_W cycles, with CNT_W overridden to 4 -> stall_count sticks at 15.

Source files
------------

// File: rtl/hazard_forward_ctrl_if.sv
// Hazard-controller signal bundle: ID-stage instruction info and branch outcome in,
// forwarding selects, pipeline enables and performance counters out.
interface hazard_forward_ctrl_if #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 16
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rs;
    logic                  id_uses_rt;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic                  branch_taken;
    logic [1:0]            fwd_a_sel;
    logic [1:0]            fwd_b_sel;
    logic                  stall;
    logic                  pc_write_en;
    logic                  ifid_write_en;
    logic                  ifid_flush;
    logic                  idex_bubble;
    logic [CNT_W-1:0]      stall_count;
    logic [CNT_W-1:0]      flush_count;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd, id_reg_write,
               id_mem_read, branch_taken,
        input  fwd_a_sel, fwd_b_sel, stall, pc_write_en, ifid_write_en, ifid_flush,
               idex_bubble, stall_count, flush_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd, id_reg_write,
               id_mem_read, branch_taken,
        output fwd_a_sel, fwd_b_sel, stall, pc_write_en, ifid_write_en, ifid_flush,
               idex_bubble, stall_count, flush_count
    );
endinterface

// File: rtl/hazard_forward_ctrl.sv
// Pipeline hazard controller: EX operand forwarding, load-use stall, branch flush,
// with a shadow copy of EX/MEM/WB register usage and saturating event counters.
module hazard_forward_ctrl #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    hazard_forward_ctrl_if.slave bus
);
    logic                  ex_valid, ex_uses_rs, ex_uses_rt, ex_wr, ex_memrd;
    logic [REG_ADDR_W-1:0] ex_rs, ex_rt, ex_rd;
    logic                  mem_valid, mem_wr;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic                  wb_valid, wb_wr;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [CNT_W-1:0]      stall_cnt, flush_cnt;
    logic                  stall, bubble;
    logic [1:0]            fwd_a, fwd_b;

    function automatic logic [1:0] fwd_sel(input logic                  uses,
                                           input logic [REG_ADDR_W-1:0] src);
        logic [1:0] sel;
        sel = 2'b00;
        if (ex_valid && uses) begin
            if (mem_valid && mem_wr && (mem_rd != '0) && (mem_rd == src)) begin
                sel = 2'b01;
            end else if (wb_valid && wb_wr && (wb_rd != '0) && (wb_rd == src)) begin
                sel = 2'b10;
            end
        end
        return sel;
    endfunction

    always_comb begin
        // A taken branch kills the ID instruction, so it cannot cause a stall.
        stall = bus.id_valid && ex_valid && ex_memrd && ex_wr && (ex_rd != '0) &&
                ((bus.id_uses_rs && (bus.id_rs == ex_rd)) ||
                 (bus.id_uses_rt && (bus.id_rt == ex_rd))) && !bus.branch_taken;
        bubble = stall || bus.branch_taken;
        fwd_a  = fwd_sel(ex_uses_rs, ex_rs);
        fwd_b  = fwd_sel(ex_uses_rt, ex_rt);
    end

    assign bus.stall         = stall;
    assign bus.pc_write_en   = !stall;
    assign bus.ifid_write_en = !stall;
    assign bus.ifid_flush    = bus.branch_taken;
    assign bus.idex_bubble   = bubble;
    assign bus.fwd_a_sel     = fwd_a;
    assign bus.fwd_b_sel     = fwd_b;
    assign bus.stall_count   = stall_cnt;
    assign bus.flush_count   = flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid   <= 1'b0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_uses_rs <= 1'b0;
            ex_uses_rt <= 1'b0;
            ex_rd      <= '0;
            ex_wr      <= 1'b0;
            ex_memrd   <= 1'b0;
            mem_valid  <= 1'b0;
            mem_rd     <= '0;
            mem_wr     <= 1'b0;
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_wr      <= 1'b0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
        end else begin
            wb_valid  <= mem_valid;
            wb_rd     <= mem_rd;
            wb_wr     <= mem_wr;
            mem_valid <= ex_valid;
            mem_rd    <= ex_rd;
            mem_wr    <= ex_wr;
            if (bubble) begin
                ex_valid   <= 1'b0;
                ex_rs      <= '0;
                ex_rt      <= '0;
                ex_uses_rs <= 1'b0;
                ex_uses_rt <= 1'b0;
                ex_rd      <= '0;
                ex_wr      <= 1'b0;
                ex_memrd   <= 1'b0;
            end else begin
                ex_valid   <= bus.id_valid;
                ex_rs      <= bus.id_rs;
                ex_rt      <= bus.id_rt;
                ex_uses_rs <= bus.id_uses_rs;
                ex_uses_rt <= bus.id_uses_rt;
                ex_rd      <= bus.id_rd;
                ex_wr      <= bus.id_reg_write;
                ex_memrd   <= bus.id_mem_read;
            end
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (bus.branch_taken && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Self-checking bench for hazard_forward_ctrl: per-cycle model comparison against a
// default-width instance and a 4-bit-counter instance, plus directed literal checks.
module tb_hazard_forward_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    hazard_forward_ctrl_if #(.REG_ADDR_W(5), .CNT_W(16)) b16 ();
    hazard_forward_ctrl_if #(.REG_ADDR_W(5), .CNT_W(4))  b4 ();

    hazard_forward_ctrl #(.REG_ADDR_W(5), .CNT_W(16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b16)
    );

    hazard_forward_ctrl #(.REG_ADDR_W(5), .CNT_W(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b4)
    );

    // Model: list of in-flight instructions, index 0 = EX, 1 = MEM, 2 = WB.
    typedef struct {
        bit v;
        int rs;
        int rt;
        bit urs;
        bit urt;
        int rd;
        bit wr;
        bit mr;
    } ent_t;

    ent_t pipe[3];
    int   m_stalls;
    int   m_flushes;

    function automatic bit reads(input ent_t e, input int r);
        return (e.urs && e.rs == r) || (e.urt && e.rt == r);
    endfunction

    function automatic bit m_stall();
        ent_t id;
        id = '{v: b16.id_valid, rs: int'(b16.id_rs), rt: int'(b16.id_rt),
               urs: b16.id_uses_rs, urt: b16.id_uses_rt, rd: int'(b16.id_rd),
               wr: b16.id_reg_write, mr: b16.id_mem_read};
        if (b16.branch_taken || !id.v) return 1'b0;
        return pipe[0].v && pipe[0].mr && pipe[0].wr && pipe[0].rd != 0 &&
               reads(id, pipe[0].rd);
    endfunction

    function automatic logic [1:0] m_fwd(input bit uses, input int src);
        if (!pipe[0].v || !uses || src == 0) return 2'b00;
        for (int s = 1; s <= 2; s++) begin
            if (pipe[s].v && pipe[s].wr && pipe[s].rd == src) return 2'(s);
        end
        return 2'b00;
    endfunction

    function automatic int sat(input int v, input int bits);
        int mx;
        mx = (1 << bits) - 1;
        return (v > mx) ? mx : v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) pipe[i] = '{default: 0};
            m_stalls  = 0;
            m_flushes = 0;
        end else begin
            bit st;
            bit br;
            st = m_stall();
            br = b16.branch_taken;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (st || br) begin
                pipe[0] = '{default: 0};
            end else begin
                pipe[0] = '{v: b16.id_valid, rs: int'(b16.id_rs), rt: int'(b16.id_rt),
                            urs: b16.id_uses_rs, urt: b16.id_uses_rt, rd: int'(b16.id_rd),
                            wr: b16.id_reg_write, mr: b16.id_mem_read};
            end
            if (st) m_stalls++;
            if (br) m_flushes++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            bit st;
            st = m_stall();
            check("cmp_stall", int'(b16.stall), int'(st));
            check("cmp_pc_we", int'(b16.pc_write_en), int'(!st));
            check("cmp_ifid_we", int'(b16.ifid_write_en), int'(!st));
            check("cmp_ifid_flush", int'(b16.ifid_flush), int'(b16.branch_taken));
            check("cmp_bubble", int'(b16.idex_bubble), int'(st || b16.branch_taken));
            check("cmp_fwd_a", int'(b16.fwd_a_sel), int'(m_fwd(pipe[0].urs, pipe[0].rs)));
            check("cmp_fwd_b", int'(b16.fwd_b_sel), int'(m_fwd(pipe[0].urt, pipe[0].rt)));
            check("cmp_stall_cnt16", int'(b16.stall_count), sat(m_stalls, 16));
            check("cmp_flush_cnt16", int'(b16.flush_count), sat(m_flushes, 16));
            check("cmp_stall4", int'(b4.stall), int'(st));
            check("cmp_stall_cnt4", int'(b4.stall_count), sat(m_stalls, 4));
            check("cmp_flush_cnt4", int'(b4.flush_count), sat(m_flushes, 4));
        end
    end

    task automatic drive(input bit v, input int rs, input int rt, input bit urs,
                         input bit urt, input int rd, input bit wr, input bit mr,
                         input bit br);
        b16.id_valid = v;      b4.id_valid = v;
        b16.id_rs = rs[4:0];   b4.id_rs = rs[4:0];
        b16.id_rt = rt[4:0];   b4.id_rt = rt[4:0];
        b16.id_uses_rs = urs;  b4.id_uses_rs = urs;
        b16.id_uses_rt = urt;  b4.id_uses_rt = urt;
        b16.id_rd = rd[4:0];   b4.id_rd = rd[4:0];
        b16.id_reg_write = wr; b4.id_reg_write = wr;
        b16.id_mem_read = mr;  b4.id_mem_read = mr;
        b16.branch_taken = br; b4.branch_taken = br;
    endtask

    // Present one ID-stage instruction for a cycle; returns just after the falling edge.
    task automatic issue(input bit v, input int rs, input int rt, input bit urs,
                         input bit urt, input int rd, input bit wr, input bit mr,
                         input bit br);
        @(posedge clk);
        #1;
        drive(v, rs, rt, urs, urt, rd, wr, mr, br);
        @(negedge clk);
        #1;
    endtask

    task automatic nop();
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic alu(input int rs, input int rt, input int rd);
        issue(1, rs, rt, rs != 0, rt != 0, rd, 1, 0, 0);
    endtask

    task automatic load(input int rd);
        issue(1, 0, 0, 0, 0, rd, 1, 1, 0);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        check("rst_fwd_a", int'(b16.fwd_a_sel), 0);
        check("rst_fwd_b", int'(b16.fwd_b_sel), 0);
        check("rst_stall", int'(b16.stall), 0);
        check("rst_pc_we", int'(b16.pc_write_en), 1);
        check("rst_ifid_we", int'(b16.ifid_write_en), 1);
        check("rst_bubble", int'(b16.idex_bubble), 0);
        check("rst_stall_cnt", int'(b16.stall_count), 0);
        #9;
        rst_n = 1'b1;

        // ALU back-to-back: MEM forward
        issue(1, 1, 2, 1, 1, 3, 1, 0, 0);
        issue(1, 3, 0, 1, 0, 4, 1, 0, 0);
        nop();
        check("b2b_fwd_a_mem", int'(b16.fwd_a_sel), 1);
        check("b2b_stall", int'(b16.stall), 0);

        // One unrelated instruction between: WB forward
        alu(1, 2, 3);
        alu(0, 0, 9);
        alu(3, 0, 4);
        nop();
        check("gap_fwd_a_wb", int'(b16.fwd_a_sel), 2);

        // r5 in both MEM and WB: MEM wins
        alu(1, 0, 5);
        alu(2, 0, 5);
        alu(0, 5, 6);
        nop();
        check("dbl_fwd_b_mem", int'(b16.fwd_b_sel), 1);

        // Register 0 never forwarded
        issue(1, 1, 0, 1, 0, 0, 1, 0, 0);
        issue(1, 0, 0, 1, 0, 8, 1, 0, 0);
        nop();
        check("r0_fwd_a", int'(b16.fwd_a_sel), 0);

        // Load-use: one stall cycle, then WB forward
        load(7);
        alu(7, 0, 8);
        check("lu_stall", int'(b16.stall), 1);
        check("lu_pc_we", int'(b16.pc_write_en), 0);
        check("lu_bubble", int'(b16.idex_bubble), 1);
        check("lu_cnt_before", int'(b16.stall_count), 0);
        alu(7, 0, 8);
        check("lu_stall_drop", int'(b16.stall), 0);
        check("lu_cnt_after", int'(b16.stall_count), 1);
        nop();
        check("lu_fwd_a_wb", int'(b16.fwd_a_sel), 2);

        // Branch over a load-use condition: flush wins
        load(7);
        issue(1, 7, 0, 1, 0, 8, 1, 0, 1);
        check("br_stall", int'(b16.stall), 0);
        check("br_flush", int'(b16.ifid_flush), 1);
        check("br_bubble", int'(b16.idex_bubble), 1);
        nop();
        check("br_flush_cnt", int'(b16.flush_count), 1);
        check("br_stall_cnt", int'(b16.stall_count), 1);

        // Asynchronous reset mid-stall
        load(7);
        alu(7, 0, 8);
        check("mid_stall_pre", int'(b16.stall), 1);
        rst_n = 1'b0;
        #1;
        check("mid_stall", int'(b16.stall), 0);
        check("mid_pc_we", int'(b16.pc_write_en), 1);
        check("mid_bubble", int'(b16.idex_bubble), 0);
        check("mid_stall_cnt", int'(b16.stall_count), 0);
        check("mid_flush_cnt", int'(b16.flush_count), 0);
        check("mid_fwd_a", int'(b16.fwd_a_sel), 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Saturation of the narrow counters
        for (int i = 0; i < 20; i++) begin
            load(7);
            alu(7, 0, 8);
        end
        nop();
        check("sat_stall4", int'(b4.stall_count), 15);
        check("sat_stall16", int'(b16.stall_count), 20);
        for (int i = 0; i < 18; i++) issue(0, 0, 0, 0, 0, 0, 0, 0, 1);
        nop();
        check("sat_flush4", int'(b4.flush_count), 15);
        check("sat_flush16", int'(b16.flush_count), 18);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
